// File: rtl/pkg_med_frec.sv
// Shared types for the frequency meter: FSM encoding and the default counter width.
package pkg_med_frec;

  localparam int WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    ESPERA,
    MIDE,
    SIN_SENAL
  } estado_t;

  typedef logic [WIDTH_DEF-1:0] ciclos_t;

endpackage

// File: rtl/module_sinc_flanco.sv
// Two-flop synchroniser for an asynchronous input followed by a registered
// any-edge detector; flanco pulses three clk cycles after d changes.
module module_sinc_flanco (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic flanco
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic flanco_q, flanco_d;

  // Shift the input through the synchroniser and compare the last two synchronised samples
  always_comb begin
    s1_d     = d;
    s2_d     = s1_q;
    s3_d     = s2_q;
    flanco_d = s2_q ^ s3_q;
  end

  // Synchroniser, delayed copy and edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      flanco_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      flanco_q <= flanco_d;
    end
  end

  assign q      = s2_q;
  assign flanco = flanco_q;

endmodule

// File: rtl/module_med_frec.sv
// Frequency meter: counts clk cycles between consecutive edges of f_in,
// reports the half-period, flags a stable (locked) period and loss of signal.
module module_med_frec
  import pkg_med_frec::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] MAX_CICLOS = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TOL        = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_in,
  output logic [WIDTH-1:0] nciclos_med,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] UNO        = WIDTH'(1);
  localparam logic [WIDTH-1:0] CUENTA_MAX = MAX_CICLOS - UNO;

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] cuenta_q, cuenta_d;
  logic [WIDTH-1:0] nciclos_q, nciclos_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             previo_q, previo_d;

  logic             flanco;
  logic             nivel_unused;
  logic             fin_cuenta;
  logic [WIDTH:0]   diferencia;
  logic             coincide;

  module_sinc_flanco u_sinc_flanco (
    .clk    (clk),
    .rst    (rst),
    .d      (f_in),
    .q      (nivel_unused),
    .flanco (flanco)
  );

  // Saturation point and the one-bit-wider absolute difference against the previous result
  always_comb begin
    fin_cuenta = (cuenta_q == CUENTA_MAX);
    if ({1'b0, cuenta_q} >= {1'b0, nciclos_q}) begin
      diferencia = {1'b0, cuenta_q} - {1'b0, nciclos_q};
    end else begin
      diferencia = {1'b0, nciclos_q} - {1'b0, cuenta_q};
    end
    coincide = (diferencia <= {1'b0, TOL});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= ESPERA;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next state: an edge always wins over the timeout condition
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA:    if (flanco) estado_d = MIDE;
      MIDE:      if (!flanco && fin_cuenta) estado_d = SIN_SENAL;
      SIN_SENAL: if (flanco) estado_d = MIDE;
      default:   estado_d = ESPERA;
    endcase
  end

  // Counter, result, lock and timeout updates; start edges never produce a result
  always_comb begin
    cuenta_d  = cuenta_q;
    nciclos_d = nciclos_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    previo_d  = previo_q;
    case (estado_q)
      ESPERA: begin
        if (flanco) begin
          cuenta_d = UNO;
          previo_d = 1'b0;
        end
      end
      MIDE: begin
        if (flanco) begin
          nciclos_d = cuenta_q;
          valid_d   = 1'b1;
          cuenta_d  = UNO;
          locked_d  = previo_q && coincide;
          previo_d  = 1'b1;
        end else if (fin_cuenta) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
        end else begin
          cuenta_d = cuenta_q + UNO;
        end
      end
      SIN_SENAL: begin
        if (flanco) begin
          timeout_d = 1'b0;
          cuenta_d  = UNO;
          previo_d  = 1'b0;
        end
      end
      default: begin
        cuenta_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_q  <= '0;
      nciclos_q <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      previo_q  <= 1'b0;
    end else begin
      cuenta_q  <= cuenta_d;
      nciclos_q <= nciclos_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      previo_q  <= previo_d;
    end
  end

  assign nciclos_med = nciclos_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_module_med_frec.sv
// Directed bench for module_med_frec: a behavioural divider drives f_in and a
// negedge monitor records every result with its lock flag and spacing.
module tb_module_med_frec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_in = 1'b0;
  logic [23:0] nciclos_med;
  logic        valid;
  logic        locked;
  logic        timeout;

  int tests_run = 0;
  int failures  = 0;

  // Divider model and recorders
  int  cyc = 0;
  bit  div_en = 1'b0;
  bit  freeze_req = 1'b0;
  int  div_n = 5;
  int  cur_n = 5;
  int  div_cnt = 0;
  int  last_tog_cyc = -1;
  int  last_v_cyc = 0;
  int  first_v_cyc = -1;
  int  to_rise_cyc = -1;
  int  to_fall_cyc = -1;
  bit  to_prev = 1'b0;
  int  vq[$];
  bit  lq[$];
  int  gq[$];

  module_med_frec #(
    .WIDTH      (24),
    .MAX_CICLOS (24'd100),
    .TOL        (24'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .f_in        (f_in),
    .nciclos_med (nciclos_med),
    .valid       (valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // On each falling edge: advance the cycle count, run the divider, record results
  always @(negedge clk) begin
    cyc++;
    if (div_en) begin
      if (div_cnt >= cur_n - 1) begin
        f_in = ~f_in;
        div_cnt = 0;
        cur_n = div_n;
        last_tog_cyc = cyc;
        if (freeze_req) div_en = 1'b0;
      end else begin
        div_cnt++;
      end
    end
    if (valid) begin
      vq.push_back(int'(nciclos_med));
      lq.push_back(locked);
      gq.push_back(cyc - last_v_cyc);
      last_v_cyc = cyc;
      if (first_v_cyc < 0) first_v_cyc = cyc;
    end
    if (timeout && !to_prev) to_rise_cyc = cyc;
    if (!timeout && to_prev && to_fall_cyc < 0) to_fall_cyc = cyc;
    to_prev = timeout;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int n);
    div_n = n;
    if (!div_en) begin
      cur_n = n;
      div_cnt = 0;
      div_en = 1'b1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_records();
    vq.delete();
    lq.delete();
    gq.delete();
  endtask

  initial begin
    int k;
    bit ok;

    // Reset state
    wait_cycles(3);
    check_output("rst_nciclos", nciclos_med, 0);
    check_output("rst_valid", valid, 0);
    check_output("rst_locked", locked, 0);
    check_output("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // 1: constant input, no first edge, so no timeout either
    clear_records();
    wait_cycles(150);
    check_output("t1_valids", vq.size(), 0);
    check_output("t1_timeout", timeout, 0);
    check_output("t1_locked", locked, 0);
    check_output("t1_nciclos", nciclos_med, 0);

    // 2: half-period of 5
    clear_records();
    apply_stimulus(5);
    wait_cycles(60);
    check_output("t2_count_ok", vq.size() >= 8, 1);
    if (vq.size() >= 8) begin
      for (int i = 0; i < 6; i++) check_output($sformatf("t2_val%0d", i), vq[i], 5);
      check_output("t2_lock0", lq[0], 0);
      check_output("t2_lock1", lq[1], 1);
      check_output("t2_lock5", lq[5], 1);
      check_output("t2_gap", gq[2], 5);
      check_output("t2_gap_last", gq[7], 5);
    end

    // 4: switch 5 -> 8, lock drops for exactly one result
    clear_records();
    apply_stimulus(8);
    wait_cycles(60);
    k = -1;
    for (int i = 0; i < vq.size(); i++) if (k < 0 && vq[i] != 5) k = i;
    check_output("t4_found", (k >= 0) && (vq.size() >= k + 3), 1);
    if ((k >= 0) && (vq.size() >= k + 3)) begin
      check_output("t4_first8", vq[k], 8);
      check_output("t4_first8_lock", lq[k], 0);
      check_output("t4_second8", vq[k+1], 8);
      check_output("t4_second8_lock", lq[k+1], 1);
      check_output("t4_third8_lock", lq[k+2], 1);
    end

    // 3: toggle every clk
    apply_stimulus(1);
    wait_cycles(40);
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("t3_valid%0d", i), valid, 1);
      check_output($sformatf("t3_nciclos%0d", i), nciclos_med, 1);
      check_output($sformatf("t3_locked%0d", i), locked, 1);
      wait_cycles(1);
    end

    // 5: lock at 5, freeze, timeout, restart
    apply_stimulus(5);
    wait_cycles(40);
    check_output("t5_locked_before", locked, 1);
    to_rise_cyc = -1;
    freeze_req = 1'b1;
    k = 0;
    while (div_en && k < 20) begin
      wait_cycles(1);
      k++;
    end
    check_output("t5_frozen", div_en, 0);
    k = 0;
    while (to_rise_cyc < 0 && k < 150) begin
      wait_cycles(1);
      k++;
    end
    check_output("t5_timeout_delay", to_rise_cyc - last_tog_cyc, 103);
    check_output("t5_timeout", timeout, 1);
    check_output("t5_locked", locked, 0);
    check_output("t5_nciclos_hold", nciclos_med, 5);
    clear_records();
    to_fall_cyc = -1;
    first_v_cyc = -1;
    freeze_req = 1'b0;
    apply_stimulus(5);
    wait_cycles(30);
    check_output("t5_timeout_cleared", to_fall_cyc > 0, 1);
    check_output("t5_restart_gap", first_v_cyc - to_fall_cyc, 5);
    check_output("t5_restart_count", vq.size() >= 2, 1);
    if (vq.size() >= 2) begin
      check_output("t5_restart_val", vq[0], 5);
      check_output("t5_restart_lock0", lq[0], 0);
      check_output("t5_restart_lock1", lq[1], 1);
    end

    // 6: one-cycle reset mid-period while f_in is low and cuenta is 3
    ok = 1'b0;
    k = 0;
    while (!ok && k < 40) begin
      wait_cycles(1);
      ok = (f_in == 1'b0) && (last_tog_cyc == cyc);
      k++;
    end
    check_output("t6_sync", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("t6_rst_nciclos", nciclos_med, 0);
    check_output("t6_rst_valid", valid, 0);
    check_output("t6_rst_locked", locked, 0);
    check_output("t6_rst_timeout", timeout, 0);
    clear_records();
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_cycles(11);
    check_output("t6_no_stale_valid", vq.size(), 0);
    wait_cycles(1);
    check_output("t6_valid", valid, 1);
    check_output("t6_nciclos", nciclos_med, 5);
    check_output("t6_locked", locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
